// File: rtl/jt12_interp_pkg.sv
// jt12_interp_pkg: shared FSM state type and width helper for the interpolator
package jt12_interp_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PRIME,
    RUN
  } state_t;

  function automatic int acc_w(input int width, input int shift);
    return width + shift + 1;
  endfunction

endpackage

// File: rtl/jt12_interp_buf.sv
// jt12_interp_buf: one-entry valid/ready holding register for incoming samples
module jt12_interp_buf
  import jt12_interp_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    pop,
  output logic signed [WIDTH-1:0] pend,
  output logic                    pend_full
);

  assign din_ready = !pend_full;

  // accept only into an empty slot, so an accept and a pop never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (din_valid && din_ready) begin
      pend      <= din;
      pend_full <= 1'b1;
    end else if (pop) begin
      pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/jt12_interp.sv
// jt12_interp: linear interpolator producing one ramp value per clk between input samples
module jt12_interp
  import jt12_interp_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SHIFT = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic signed [WIDTH-1:0] dout,
  output logic                    underrun
);

  localparam int AW = acc_w(WIDTH, SHIFT);

  logic signed [WIDTH-1:0] pend, cur;
  logic                    pend_full, pop, load, seg;
  logic signed [WIDTH:0]   delta;
  logic signed [AW-1:0]    acc;
  logic [SHIFT-1:0]        phase;
  state_t                  st, st_nx;

  jt12_interp_buf #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .pop      (pop),
    .pend     (pend),
    .pend_full(pend_full)
  );

  assign dout = acc[WIDTH+SHIFT-1:SHIFT];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= EMPTY;
    else        st <= st_nx;
  end

  // load first sample, start segments at priming and at each phase wrap
  always_comb begin
    load  = (st == EMPTY) && pend_full;
    seg   = ((st == PRIME) && pend_full) || ((st == RUN) && (&phase));
    pop   = load || (seg && pend_full);
    st_nx = load ? PRIME : (seg ? RUN : st);
  end

  // accumulator walks by delta each cycle and reloads exactly at each segment start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      delta    <= '0;
      acc      <= '0;
      phase    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= seg && !pend_full;
      if (load) begin
        cur <= pend;
        acc <= {pend[WIDTH-1], pend, {SHIFT{1'b0}}};
      end else if (seg) begin
        acc   <= {cur[WIDTH-1], cur, {SHIFT{1'b0}}};
        phase <= '0;
        delta <= pend_full ? ({pend[WIDTH-1], pend} - {cur[WIDTH-1], cur}) : '0;
        if (pend_full) cur <= pend;
      end else if (st == RUN) begin
        acc   <= acc + {{(AW-WIDTH-1){delta[WIDTH]}}, delta};
        phase <= phase + 1'b1;
      end
    end
  end

endmodule
